pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Programmable pulse-train generator: on a start request it emits a configurable number of rising edges on a single output, each with a programmable high and low duration in clock cycles, then reports completion. It is the stimulus counterpart to the edge-counting monitor counters. It drives test/calibration strobes and self-checks the monitor path: a train of N pulses must read back as N counted rising edges.

## Interface
- CNT_WIDTH, 16, width of pulse-count request and sent-pulse counter (≥1)
- PERIOD_WIDTH, 8, width of high/low phase length fields (≥1)

- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  start request; sampled only when idle
- abort_i  input  1  stop the train immediately
- num_pulses_i  input  CNT_WIDTH  number of pulses in train; sampled on accepted start
- high_cycles_i  input  PERIOD_WIDTH  high phase length in cycles; 0 treated as 1
- low_cycles_i  input  PERIOD_WIDTH  low phase length in cycles; 0 treated as 1
- pulse_o  output  1  generated pulse train, registered
- busy_o  output  1  train in progress
- done_o  output  1  one-cycle strobe on normal completion
- pulses_sent_o  output  CNT_WIDTH  rising edges emitted in current/last train

## Operation
- States: IDLE, HIGH, LOW, FINISH.
- IDLE: pulse_o=0, busy_o=0. start_i=1 and abort_i=0 accepts the start: num_pulses_i, high_cycles_i, low_cycles_i are latched and pulses_sent_o clears to 0.
  - Request ≠0 → HIGH.
  - Request =0 → FINISH; no pulse is emitted.
- HIGH: pulse_o=1 for H cycles (H = max(high_cycles,1)).
  - pulses_sent_o increments by 1 on the first cycle of each HIGH phase.
  - Then → LOW.
- LOW: pulse_o=0 for L cycles (L = max(low_cycles,1)).
  - Then → HIGH if pulses_sent_o < request, else → FINISH.
  - The last pulse always gets its full low phase, so back-to-back trains stay edge-separated.
- FINISH: one cycle. done_o=1, busy_o=0, → IDLE.
- busy_o=1 in HIGH and LOW only.
- start_i outside IDLE is ignored; it is not queued.
- abort_i=1 in HIGH or LOW: next cycle IDLE, pulse_o=0, done_o stays 0, pulses_sent_o holds.
- abort_i in IDLE or FINISH has no effect.
- abort_i and start_i together in IDLE: abort wins and the start is dropped.
- Changes on config inputs during a train have no effect.
- Arithmetic: phase timer is a PERIOD_WIDTH down-counter; pulse counter is a CNT_WIDTH up-counter. The maximum request 2^CNT_WIDTH-1 completes without wrap.

## Timing
- Reset (any state): next edge gives IDLE, pulse_o=0, busy_o=0, done_o=0, pulses_sent_o=0, latched config=0.
- Start accepted at edge T:
  - pulse_o and busy_o are high from cycle T+1.
  - pulses_sent_o=1 from T+1.
- Pulse k (1-based) rises at T+1+(k-1)(H+L).
- done_o is asserted at cycle T+1+N(H+L). The total train length is N(H+L) cycles.
- Zero request: done_o is asserted at T+1 and pulse_o never rises.
- The earliest next start is accepted on the cycle after done_o.
- Abort sampled at edge A: pulse_o=0 and busy_o=0 at A+1.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package pulse_train_gen_pkg:
  - state enum typedef (IDLE, HIGH, LOW, FINISH)
  - helper function clamping a zero phase length to 1
- One sub-module, pulse_phase_timer: loadable PERIOD_WIDTH down-counter with load/value inputs and an expire strobe. It is instantiated once and reloaded at each phase change.
- The top level holds the FSM, latched config, and the pulses_sent_o counter.

## Test plan
- N=3, H=2, L=3, start at T: pulse_o high at T+1..T+2, T+6..T+7, T+11..T+12; done_o at T+16; pulses_sent_o=3.
- N=0: done_o at T+1, pulse_o stays 0, pulses_sent_o=0, busy_o never high.
- N=2, H=0, L=0 (clamped to 1): pulse_o toggles 1,0,1,0 from T+1; done_o at T+5.
- N=5, H=1, L=1:
  - abort during 3rd HIGH → pulse_o=0 next cycle, no done_o, pulses_sent_o=3.
  - start_i held throughout is ignored until IDLE.
- rst_i asserted mid-LOW of N=4 train → all outputs 0 next cycle; a new start afterwards produces a full correct train.
- Loopback: pulse_o feeds the edge-counting monitor. Random N (1..1000), H, L (0..255) → monitor count equals N and equals pulses_sent_o at done_o.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and helpers for the pulse-train generator.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Phase lengths travel through this helper at a fixed width; callers cast back.
  localparam int PHASE_FN_W = 32;

  function automatic logic [PHASE_FN_W-1:0] clamp_phase(input logic [PHASE_FN_W-1:0] len);
    return (len == '0) ? PHASE_FN_W'(1) : len;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expire_o marks the last cycle.
module pulse_phase_timer #(
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [PERIOD_WIDTH-1:0] value_i,
  output logic                    expire_o
);

  logic [PERIOD_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = value_i;
    else if (en_i && (count_q != '0))
      count_d = count_q - PERIOD_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // A value of 1 means this is the final cycle of the loaded phase.
  assign expire_o = en_i && (count_q == PERIOD_WIDTH'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles, then a done strobe.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CNT_WIDTH-1:0]    num_pulses_i,
  input  logic [PERIOD_WIDTH-1:0] high_cycles_i,
  input  logic [PERIOD_WIDTH-1:0] low_cycles_i,
  output logic                    pulse_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    pulses_sent_o
);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    req_q, req_d;
  logic [CNT_WIDTH-1:0]    sent_q, sent_d;
  logic [PERIOD_WIDTH-1:0] high_q, high_d;
  logic [PERIOD_WIDTH-1:0] low_q, low_d;
  logic                    pulse_q, busy_q, done_q;

  logic                    tmr_load, tmr_en, tmr_expire;
  logic [PERIOD_WIDTH-1:0] tmr_val;
  logic [PERIOD_WIDTH-1:0] high_in_eff, high_eff, low_eff;

  assign high_in_eff = PERIOD_WIDTH'(clamp_phase(PHASE_FN_W'(high_cycles_i)));
  assign high_eff    = PERIOD_WIDTH'(clamp_phase(PHASE_FN_W'(high_q)));
  assign low_eff     = PERIOD_WIDTH'(clamp_phase(PHASE_FN_W'(low_q)));

  assign tmr_en = (state_q == ST_HIGH) || (state_q == ST_LOW);

  pulse_phase_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .value_i  (tmr_val),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sent_d   = sent_q;
    high_d   = high_q;
    low_d    = low_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          req_d  = num_pulses_i;
          high_d = high_cycles_i;
          low_d  = low_cycles_i;
          sent_d = '0;
          if (num_pulses_i != '0) begin
            state_d  = ST_HIGH;
            sent_d   = CNT_WIDTH'(1);
            tmr_load = 1'b1;
            tmr_val  = high_in_eff;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_HIGH: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = low_eff;
        end
      end
      ST_LOW: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          // The last pulse keeps its full low phase before FINISH.
          if (sent_q < req_q) begin
            state_d  = ST_HIGH;
            sent_d   = sent_q + CNT_WIDTH'(1);
            tmr_load = 1'b1;
            tmr_val  = high_eff;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      sent_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sent_q  <= sent_d;
      high_q  <= high_d;
      low_q   <= low_d;
      pulse_q <= (state_d == ST_HIGH);
      busy_q  <= (state_d == ST_HIGH) || (state_d == ST_LOW);
      done_q  <= (state_d == ST_FINISH);
    end
  end

  assign pulse_o       = pulse_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pulses_sent_o = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench: stimulus pushes expected rise/done events, a negedge monitor checks them.
module tb_pulse_train_gen;
  localparam int CW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [CW-1:0] num;
  logic [PW-1:0] hi, lo;
  logic          pulse_o, busy_o, done_o;
  logic [CW-1:0] sent_o;

  pulse_train_gen #(.CNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .num_pulses_i  (num),
    .high_cycles_i (hi),
    .low_cycles_i  (lo),
    .pulse_o       (pulse_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pulses_sent_o (sent_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int h; } rise_t;
  typedef struct { int cyc; int n; } done_t;
  rise_t rise_q[$];
  done_t done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: pulse k rises at T+1+(k-1)(H+L), done at T+1+N(H+L).
  task automatic push_train(input int t, input int n, input int h, input int l,
                            input int max_cyc, input bit with_done);
    int p;
    p = eff(h) + eff(l);
    for (int k = 1; k <= n; k++) begin
      if (max_cyc < 0 || t + 1 + (k - 1) * p <= max_cyc)
        rise_q.push_back('{cyc: t + 1 + (k - 1) * p, h: eff(h)});
    end
    if (with_done) done_q.push_back('{cyc: t + 1 + n * p, n: n});
  endtask

  task automatic issue(input int n, input int h, input int l, input int max_rel,
                       input bit with_done, output int t);
    num   = CW'(n);
    hi    = PW'(h);
    lo    = PW'(l);
    start = 1'b1;
    t     = cyc;
    push_train(t, n, h, l, (max_rel < 0) ? -1 : t + max_rel, with_done);
    wait_cyc(t + 1);
    start = 1'b0;
  endtask

  // Monitor with loopback edge counter.
  logic  prev_p = 1'b0;
  int    exp_fall = 0;
  int    mon_cnt = 0;
  rise_t r;
  done_t d;

  always @(negedge clk) begin
    if (cyc >= 3) begin
      if (pulse_o === 1'b1 && prev_p === 1'b0) begin
        mon_cnt++;
        if (rise_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rise: got rise at cycle %0d required none", cyc);
        end else begin
          r = rise_q.pop_front();
          chk("rise_cyc", 64'(cyc), 64'(r.cyc));
          exp_fall = cyc + r.h;
        end
      end else if (pulse_o === 1'b0 && prev_p === 1'b1) begin
        chk("fall_cyc", 64'(cyc), 64'(exp_fall));
      end
      if (done_o === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
        end else begin
          d = done_q.pop_front();
          chk("done_cyc", 64'(cyc), 64'(d.cyc));
          chk("done_sent", 64'(sent_o), 64'(d.n));
          chk("loop_count", 64'(mon_cnt), 64'(d.n));
        end
        mon_cnt = 0;
      end else if (busy_o !== 1'b1) begin
        mon_cnt = 0;
      end
    end
    prev_p = pulse_o;
  end

  initial begin
    int t, n, h, l;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num = '0; hi = '0; lo = '0;
    wait_cyc(3);
    chk("rst_pulse", 64'(pulse_o), 64'd0);
    chk("rst_busy",  64'(busy_o),  64'd0);
    chk("rst_done",  64'(done_o),  64'd0);
    chk("rst_sent",  64'(sent_o),  64'd0);
    rst = 1'b0;
    wait_cyc(cyc + 1);

    // N=3 H=2 L=3
    issue(3, 2, 3, -1, 1'b1, t);
    chk("t1_busy",  64'(busy_o),  64'd1);
    chk("t1_pulse", 64'(pulse_o), 64'd1);
    chk("t1_sent",  64'(sent_o),  64'd1);
    wait_cyc(t + 17);

    // Zero request
    issue(0, 5, 5, -1, 1'b1, t);
    chk("z_done",  64'(done_o),  64'd1);
    chk("z_busy",  64'(busy_o),  64'd0);
    chk("z_pulse", 64'(pulse_o), 64'd0);
    chk("z_sent",  64'(sent_o),  64'd0);
    wait_cyc(t + 3);

    // Zero phase lengths clamp to 1
    issue(2, 0, 0, -1, 1'b1, t);
    for (int i = 0; i < 4; i++) begin
      chk("clamp_wave", 64'(pulse_o), 64'((i % 2) == 0));
      wait_cyc(cyc + 1);
    end
    wait_cyc(t + 7);

    // Abort during 3rd HIGH with start held and config wiggling
    num = CW'(5); hi = PW'(1); lo = PW'(1); start = 1'b1;
    t = cyc;
    push_train(t, 5, 1, 1, t + 5, 1'b0);
    wait_cyc(t + 1);
    num = CW'(9); hi = PW'(7);
    wait_cyc(t + 5);
    abort = 1'b1;
    wait_cyc(t + 6);
    abort = 1'b0; start = 1'b0;
    chk("ab_pulse", 64'(pulse_o), 64'd0);
    chk("ab_busy",  64'(busy_o),  64'd0);
    chk("ab_done",  64'(done_o),  64'd0);
    chk("ab_sent",  64'(sent_o),  64'd3);
    wait_cyc(t + 12);

    // Start held through a train is taken only on the cycle after done
    num = CW'(2); hi = PW'(1); lo = PW'(1); start = 1'b1;
    t = cyc;
    push_train(t, 2, 1, 1, -1, 1'b1);
    wait_cyc(t + 1);
    num = CW'(1); hi = PW'(3); lo = PW'(0);
    push_train(t + 6, 1, 3, 0, -1, 1'b1);
    wait_cyc(t + 7);
    start = 1'b0;
    wait_cyc(t + 13);

    // Reset in the middle of the 2nd LOW phase
    issue(4, 2, 3, 9, 1'b0, t);
    wait_cyc(t + 9);
    rst = 1'b1;
    wait_cyc(t + 10);
    rst = 1'b0;
    chk("mr_pulse", 64'(pulse_o), 64'd0);
    chk("mr_busy",  64'(busy_o),  64'd0);
    chk("mr_done",  64'(done_o),  64'd0);
    chk("mr_sent",  64'(sent_o),  64'd0);
    wait_cyc(t + 12);
    issue(4, 2, 3, -1, 1'b1, t);
    wait_cyc(t + 2 + 4 * 5);

    // Random loopback trains
    for (int j = 0; j < 6; j++) begin
      if (j < 3) begin
        n = $urandom_range(1, 1000); h = $urandom_range(0, 3);   l = $urandom_range(0, 3);
      end else begin
        n = $urandom_range(1, 20);   h = $urandom_range(0, 255); l = $urandom_range(0, 255);
      end
      issue(n, h, l, -1, 1'b1, t);
      wait_cyc(t + 2 + n * (eff(h) + eff(l)));
    end

    wait_cyc(cyc + 5);
    chk("rise_q_drained", 64'(rise_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
